fpu_cmd_issuer: RTL
===================

# fpu_cmd_issuer

Sequencing front end for the combinational FPU. It accepts one operation request at a time on a valid/ready port and drives the FPU operand and opcode inputs from registers. It waits for the FPU result and its registered status flags to settle, then returns result, flags and tag on a valid/ready response port. It also keeps sticky status flags. It sits between the instruction/command source and the FPU, which the parent instantiates alongside it.

## Interface
- RESULT_WAIT, 1: cycles after the flag-settle edge before capture; must be ≥1.
- TAG_W, 4: width of the request/response tag.

- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a, req_b  in  32  IEEE-754 single-precision operands.
- req_op  in  2  operation: 00 add, 01 sub, 10 mul, 11 NOP.
- req_tag  in  TAG_W  opaque ID, returned with the response.
- fpu_a, fpu_b  out  32  registered operands to the FPU.
- fpu_opcode  out  2  registered opcode to the FPU.
- fpu_o  in  32  FPU result.
- fpu_flags  in  7  FPU flags: [0] inf_B, [1] inf_A, [2] NaN_B, [3] NaN_A, [4] sign, [5] zero, [6] NOP.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_o  out  32  captured result.
- rsp_flags  out  7  captured flags.
- rsp_tag  out  TAG_W  tag of the request.
- sticky_flags  out  7  OR of all captured rsp_flags since the last clear.
- sticky_clr  in  1  clears sticky_flags.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - SETTLE: one cycle, lets the FPU register its flags.
  - WAIT: counts RESULT_WAIT−1 down to 0.
  - RESP: rsp_valid=1.
- Accept in IDLE (req_op≠11):
  - fpu_a, fpu_b, fpu_opcode and the internal tag load from the request.
  - Next state is SETTLE.
- SETTLE → WAIT, counter loaded with RESULT_WAIT−1.
- WAIT, counter=0: capture fpu_o and fpu_flags into rsp_o and rsp_flags, then go to RESP. Otherwise decrement the counter.
- NOP request (req_op=11):
  - Skips the FPU: fpu_* are not reloaded.
  - Next state is RESP, with rsp_o=0 and rsp_flags=7'h40.
- RESP:
  - Holds rsp_* stable until rsp_valid&&rsp_ready.
  - req_ready=rsp_ready. A request offered in the same cycle is accepted in the same cycle (back-to-back), and the FSM goes to SETTLE, or to RESP for a NOP.
  - With no new request, return to IDLE.
- fpu_a, fpu_b and fpu_opcode hold their last values until the next non-NOP accept. This keeps the FPU flag register stable.
- Sticky flags update every cycle: sticky ← (sticky_clr ? 0 : sticky) | (capture ? captured_flags : 0). If a clear and a capture happen in the same cycle, the new capture survives.
- Reset values:
  - FSM in IDLE; req_ready=1 after reset deasserts.
  - rsp_valid=0, rsp_o=0, rsp_flags=0, rsp_tag=0.
  - fpu_a=0, fpu_b=0, fpu_opcode=2'b11 (FPU idle as NOP).
  - sticky_flags=0, busy=0.
- Reset mid-operation: the in-flight request is dropped and no response is issued.

## Timing
- Accept at edge E0 → fpu_* valid after E0.
- The FPU registers its flags at E1.
- Capture at E(1+RESULT_WAIT); rsp_valid is high after that edge. Default: 2 cycles after accept.
- NOP: rsp_valid is high after E0+1.
- Maximum throughput: one FPU operation every RESULT_WAIT+2 cycles when rsp_ready is held high.
- req_ready is a combinational function of state and rsp_ready only. There is no path from req_valid.

## Structure
- Shared package fpu_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_NOP=2'b11;
  - flag bit indices FLG_INF_B=0 through FLG_NOP=6;
  - the issuer state enum.
- No sub-module. The FPU is instantiated by the parent, not inside this block.

## Test plan
- Add: req_a=0x3F800000, req_b=0x40000000, op=00, tag=3 → after 2 cycles rsp_o=0x40400000, rsp_flags=7'h00, rsp_tag=3.
- Multiply: req_a=0x40000000, req_b=0x40400000, op=10 → rsp_o=0x40C00000, rsp_flags=7'h00.
- Subtract equal operands: req_a=req_b=0x40490FDB, op=01 → rsp_o=0, rsp_flags=7'h20. Then sticky_flags=7'h20; sticky_clr pulsed together with the next capture leaves only that capture's flags.
- NaN operand: req_a=0x7FC00000, req_b=0x3F800000, op=00 → rsp_o=0x7FC00000, rsp_flags=7'h08.
- NOP and backpressure:
  - op=11 → rsp_valid after 1 cycle, rsp_o=0, rsp_flags=7'h40, fpu_opcode unchanged.
  - rsp_ready low for 5 cycles → rsp_* stable and req_ready=0 throughout.
  - Then a back-to-back accept in the release cycle.
- Reset mid-WAIT: rst_n low for 1 cycle → rsp_valid never asserts for that request; fpu_opcode=11; req_ready=1 after reset.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, flag bit positions and the issuer FSM encoding.
// No logic; imported by the issuer, its interface and the bench.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam int FLAG_W    = 7;
  localparam int FLG_INF_B = 0;
  localparam int FLG_INF_A = 1;
  localparam int FLG_NAN_B = 2;
  localparam int FLG_NAN_A = 3;
  localparam int FLG_SIGN  = 4;
  localparam int FLG_ZERO  = 5;
  localparam int FLG_NOP   = 6;

  localparam logic [FLAG_W-1:0] NOP_FLAGS = 7'b1 << FLG_NOP;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } issuer_state_e;

endpackage

// File: rtl/fpu_cmd_issuer_if.sv
// Request/response handshake bundle between a command source and the FPU issuer.
// master = command source / response consumer, slave = issuer.
interface fpu_cmd_issuer_if #(
  parameter int TAG_W = 4
);
  import fpu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_a;
  logic [31:0]       req_b;
  logic [1:0]        req_op;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_o;
  logic [FLAG_W-1:0] rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_o, rsp_flags, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_o, rsp_flags, rsp_tag
  );

endinterface

// File: rtl/fpu_cmd_issuer.sv
// Sequences one FPU op at a time: response RESULT_WAIT+1 edges after accept (NOP: next edge).
// Response is held under backpressure; req_ready depends only on state and rsp_ready.
module fpu_cmd_issuer
  import fpu_pkg::*;
#(
  parameter int RESULT_WAIT = 1,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fpu_cmd_issuer_if.slave   cmd,
  output logic [31:0]       fpu_a,
  output logic [31:0]       fpu_b,
  output logic [1:0]        fpu_opcode,
  input  logic [31:0]       fpu_o,
  input  logic [FLAG_W-1:0] fpu_flags,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              sticky_clr,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETTLE = ST_SETTLE;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_RESP   = ST_RESP;

  // Counter only ever holds RESULT_WAIT-1 down to 0.
  localparam int CNT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       rsp_o_q;
  logic [FLAG_W-1:0] rsp_flags_q;

  logic              accept;
  logic              is_nop;
  logic              capture;
  logic              rsp_load;
  logic [FLAG_W-1:0] rsp_flags_d;

  assign cmd.req_ready = (state == S_IDLE) || ((state == S_RESP) && cmd.rsp_ready);
  assign accept        = cmd.req_valid && cmd.req_ready;
  assign is_nop        = (cmd.req_op == OP_NOP);
  assign capture       = (state == S_WAIT) && (cnt == '0);
  assign rsp_load      = capture || (accept && is_nop);
  assign rsp_flags_d   = capture ? fpu_flags : NOP_FLAGS;

  assign cmd.rsp_valid = (state == S_RESP);
  assign cmd.rsp_o     = rsp_o_q;
  assign cmd.rsp_flags = rsp_flags_q;
  assign cmd.rsp_tag   = tag_q;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state <= is_nop ? S_RESP : S_SETTLE;
        end
        S_SETTLE: begin
          state <= S_WAIT;
          cnt   <= CNT_W'(RESULT_WAIT - 1);
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        S_RESP: begin
          if (accept)             state <= is_nop ? S_RESP : S_SETTLE;
          else if (cmd.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FPU operands only move on a real op so its flag register stays quiet across NOPs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= OP_NOP;
      tag_q      <= '0;
    end else if (accept) begin
      tag_q <= cmd.req_tag;
      if (!is_nop) begin
        fpu_a      <= cmd.req_a;
        fpu_b      <= cmd.req_b;
        fpu_opcode <= cmd.req_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_o_q     <= '0;
      rsp_flags_q <= '0;
    end else if (rsp_load) begin
      rsp_o_q     <= capture ? fpu_o : 32'h0;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  // A capture in the same cycle as a clear survives the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else begin
      sticky_flags <= (sticky_clr ? '0 : sticky_flags) | (rsp_load ? rsp_flags_d : '0);
    end
  end

endmodule
